// File: rtl/arm7tdmi_mem_arbiter_pkg.sv
// Shared types for the ARM7TDMI memory arbiter.
// Arbiter state encoding and default fetch-starve limit.
package arm7tdmi_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/arm7tdmi_mem_arbiter.sv
// Fetch/data arbiter onto a single shared memory port.
// Data wins ties unless a pending fetch has been starved too long.
module arm7tdmi_mem_arbiter
  import arm7tdmi_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_vaddr,
  input  logic        imem_req,
  input  logic        imem_write,
  input  logic [1:0]  imem_size,
  input  logic [31:0] imem_wdata,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_abort,
  input  logic [31:0] dmem_vaddr,
  input  logic        dmem_req,
  input  logic        dmem_write,
  input  logic [1:0]  dmem_size,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_lock,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_abort,
  output logic [31:0] bus_addr,
  output logic        bus_req,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  input  logic        bus_abort,
  output logic        grant_d
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] starve, starve_nxt;
  logic          starved;
  logic          done;

  assign starved = (starve == LIMIT) && imem_req;
  assign done    = bus_ready | bus_abort;
  assign grant_d = (state == GNT_D);

  // State and starve counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  // Arbitration decision and grant release.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    unique case (state)
      IDLE: begin
        if (dmem_req && !starved) begin
          state_nxt = GNT_D;
          if (imem_req && (starve != LIMIT))
            starve_nxt = starve + 1'b1;
        end else if (imem_req) begin
          state_nxt  = GNT_I;
          starve_nxt = '0;
        end
      end
      GNT_I: begin
        if (!imem_req || done)
          state_nxt = IDLE;
      end
      GNT_D: begin
        if (!dmem_req)
          state_nxt = IDLE;
        else if (done && !dmem_lock)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Route the granted side onto the bus and the bus response back.
  always_comb begin
    bus_addr   = '0;
    bus_req    = 1'b0;
    bus_write  = 1'b0;
    bus_size   = '0;
    bus_wdata  = '0;
    imem_rdata = '0;
    imem_ready = 1'b0;
    imem_abort = 1'b0;
    dmem_rdata = '0;
    dmem_ready = 1'b0;
    dmem_abort = 1'b0;
    unique case (state)
      GNT_I: begin
        bus_addr   = imem_vaddr;
        bus_req    = imem_req;
        bus_write  = imem_write;
        bus_size   = imem_size;
        bus_wdata  = imem_wdata;
        imem_rdata = bus_rdata;
        imem_ready = bus_ready;
        imem_abort = bus_abort;
      end
      GNT_D: begin
        bus_addr   = dmem_vaddr;
        bus_req    = dmem_req;
        bus_write  = dmem_write;
        bus_size   = dmem_size;
        bus_wdata  = dmem_wdata;
        dmem_rdata = bus_rdata;
        dmem_ready = bus_ready;
        dmem_abort = bus_abort;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm7tdmi_mem_arbiter.sv
// Bench for arm7tdmi_mem_arbiter.
// Directed scenarios plus randomized traffic vs a reference model.
module tb_arm7tdmi_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_vaddr, imem_wdata, imem_rdata;
  logic        imem_req, imem_write, imem_ready, imem_abort;
  logic [1:0]  imem_size;
  logic [31:0] dmem_vaddr, dmem_wdata, dmem_rdata;
  logic        dmem_req, dmem_write, dmem_lock;
  logic        dmem_ready, dmem_abort;
  logic [1:0]  dmem_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_req, bus_write, bus_ready, bus_abort;
  logic [1:0]  bus_size;
  logic        grant_d;
  logic [136:0] all_out;

  int tests = 0;
  int fails = 0;

  arm7tdmi_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_vaddr(imem_vaddr), .imem_req(imem_req),
    .imem_write(imem_write), .imem_size(imem_size),
    .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_abort(imem_abort),
    .dmem_vaddr(dmem_vaddr), .dmem_req(dmem_req),
    .dmem_write(dmem_write), .dmem_size(dmem_size),
    .dmem_wdata(dmem_wdata), .dmem_lock(dmem_lock),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_abort(dmem_abort),
    .bus_addr(bus_addr), .bus_req(bus_req),
    .bus_write(bus_write), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .bus_abort(bus_abort),
    .grant_d(grant_d)
  );

  assign all_out = {bus_req, bus_addr, bus_write, bus_size,
                    bus_wdata, imem_ready, imem_abort, imem_rdata,
                    dmem_ready, dmem_abort, dmem_rdata, grant_d};

  always #5 clk = ~clk;

  task automatic idle_inputs();
    imem_vaddr = '0; imem_req = 0; imem_write = 0;
    imem_size = '0; imem_wdata = '0;
    dmem_vaddr = '0; dmem_req = 0; dmem_write = 0;
    dmem_size = '0; dmem_wdata = '0; dmem_lock = 0;
    bus_rdata = '0; bus_ready = 0; bus_abort = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 1;
    idle_inputs();
    settle();
    imem_req = 1; dmem_req = 1;
    imem_vaddr = 32'h1234; dmem_vaddr = 32'h5678;
    bus_ready = 1; bus_abort = 1; bus_rdata = 32'hDEADBEEF;
    rst_n = 0;
    #1;
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL reset_async got=%h want=0", all_out);
    end
    tick();
    tick();
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL reset_held got=%h want=0", all_out);
    end
    idle_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_fetch();
    int pulses;
    do_reset();
    bus_ready = 1; bus_rdata = 32'hE3A00001;
    imem_req = 1; imem_vaddr = 32'h0;
    settle();
    tests++;
    if (bus_req !== 1'b0) begin
      fails++;
      $display("FAIL fetch_bubble bus_req=%b want=0", bus_req);
    end
    tick();
    settle();
    tests++;
    if ({bus_req, grant_d, bus_addr, imem_ready, imem_rdata}
        !== {1'b1, 1'b0, 32'h0, 1'b1, 32'hE3A00001}) begin
      fails++;
      $display("FAIL fetch_xfer req=%b gd=%b addr=%h rdy=%b rd=%h",
               bus_req, grant_d, bus_addr, imem_ready, imem_rdata);
    end
    pulses = imem_ready ? 1 : 0;
    tick();
    imem_req = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (imem_ready) pulses++;
      tick();
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL fetch_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_priority();
    do_reset();
    imem_req = 1; imem_vaddr = 32'h40;
    dmem_req = 1; dmem_vaddr = 32'h100;
    bus_rdata = 32'h1111_2222;
    settle();
    tick();
    settle();
    tests++;
    if ({grant_d, bus_req, bus_addr, imem_ready}
        !== {1'b1, 1'b1, 32'h100, 1'b0}) begin
      fails++;
      $display("FAIL prio_data_first gd=%b req=%b addr=%h irdy=%b",
               grant_d, bus_req, bus_addr, imem_ready);
    end
    tick();
    bus_ready = 1;
    settle();
    tests++;
    if ({dmem_ready, dmem_rdata, imem_ready}
        !== {1'b1, 32'h1111_2222, 1'b0}) begin
      fails++;
      $display("FAIL prio_data_done drdy=%b drd=%h irdy=%b",
               dmem_ready, dmem_rdata, imem_ready);
    end
    tick();
    dmem_req = 0;
    settle();
    tests++;
    if ({bus_req, grant_d, imem_ready} !== 3'b000) begin
      fails++;
      $display("FAIL prio_bubble req=%b gd=%b irdy=%b",
               bus_req, grant_d, imem_ready);
    end
    tick();
    settle();
    tests++;
    if ({grant_d, bus_addr, imem_ready} !== {1'b0, 32'h40, 1'b1}) begin
      fails++;
      $display("FAIL prio_fetch_next gd=%b addr=%h irdy=%b",
               grant_d, bus_addr, imem_ready);
    end
    tick();
    imem_req = 0;
  endtask

  task automatic test_starve();
    int k;
    int d_before;
    bit seen_i;
    logic want_d;
    do_reset();
    imem_req = 1; imem_vaddr = 32'h40;
    dmem_req = 1; dmem_vaddr = 32'h300;
    bus_ready = 1;
    k = 0; d_before = 0; seen_i = 0;
    for (int c = 0; c < 14; c++) begin
      settle();
      tests++;
      if (c % 2 == 0) begin
        if (bus_req !== 1'b0) begin
          fails++;
          $display("FAIL starve_bubble c=%0d bus_req=%b want=0",
                   c, bus_req);
        end
      end else begin
        want_d = (k != LIMIT);
        if ({bus_req, grant_d, bus_addr}
            !== {1'b1, want_d, want_d ? 32'h300 : 32'h40}) begin
          fails++;
          $display("FAIL starve_grant k=%0d gd=%b want=%b addr=%h",
                   k, grant_d, want_d, bus_addr);
        end
        if (!grant_d) seen_i = 1;
        else if (!seen_i) d_before++;
        k++;
      end
      tick();
    end
    tests++;
    if (d_before != LIMIT) begin
      fails++;
      $display("FAIL starve_count got=%0d want=%0d", d_before, LIMIT);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    imem_req = 1; imem_vaddr = 32'h80;
    dmem_req = 1; dmem_lock = 1;
    dmem_vaddr = 32'h200; dmem_write = 0;
    bus_ready = 1; bus_rdata = 32'hAA;
    settle();
    tick();
    settle();
    tests++;
    if ({grant_d, bus_addr, bus_write, dmem_ready, dmem_rdata}
        !== {1'b1, 32'h200, 1'b0, 1'b1, 32'hAA}) begin
      fails++;
      $display("FAIL lock_read gd=%b addr=%h wr=%b rdy=%b rd=%h",
               grant_d, bus_addr, bus_write, dmem_ready, dmem_rdata);
    end
    tick();
    dmem_write = 1; dmem_wdata = 32'h55; dmem_lock = 0;
    settle();
    tests++;
    if ({grant_d, bus_req, bus_write, bus_addr, bus_wdata, imem_ready}
        !== {1'b1, 1'b1, 1'b1, 32'h200, 32'h55, 1'b0}) begin
      fails++;
      $display("FAIL lock_write gd=%b req=%b wr=%b addr=%h wd=%h",
               grant_d, bus_req, bus_write, bus_addr, bus_wdata);
    end
    tick();
    dmem_req = 0;
    settle();
    tests++;
    if ({bus_req, grant_d} !== 2'b00) begin
      fails++;
      $display("FAIL lock_bubble req=%b gd=%b want=00",
               bus_req, grant_d);
    end
    tick();
    settle();
    tests++;
    if ({grant_d, bus_addr, imem_ready} !== {1'b0, 32'h80, 1'b1}) begin
      fails++;
      $display("FAIL lock_fetch gd=%b addr=%h irdy=%b",
               grant_d, bus_addr, imem_ready);
    end
    tick();
    imem_req = 0;
  endtask

  task automatic test_abort();
    do_reset();
    imem_req = 1; imem_vaddr = 32'h1000;
    bus_abort = 1;
    settle();
    tick();
    settle();
    tests++;
    if ({bus_addr, imem_abort, imem_ready}
        !== {32'h1000, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL abort_fwd addr=%h abt=%b rdy=%b",
               bus_addr, imem_abort, imem_ready);
    end
    tick();
    bus_abort = 0;
    settle();
    tests++;
    if ({bus_req, imem_abort, imem_ready} !== 3'b000) begin
      fails++;
      $display("FAIL abort_idle req=%b abt=%b rdy=%b",
               bus_req, imem_abort, imem_ready);
    end
    tick();
    settle();
    tests++;
    if (bus_req !== 1'b1) begin
      fails++;
      $display("FAIL abort_regrant bus_req=%b want=1", bus_req);
    end
    tick();
    imem_req = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    dmem_req = 1; dmem_vaddr = 32'h400;
    imem_req = 1; imem_vaddr = 32'hC0;
    settle();
    tick();
    settle();
    tests++;
    if (grant_d !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_gnt grant_d=%b want=1", grant_d);
    end
    #2;
    rst_n = 0;
    bus_ready = 1; bus_rdata = 32'h77;
    #1;
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL rstmid_async got=%h want=0", all_out);
    end
    tick();
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL rstmid_held got=%h want=0", all_out);
    end
    dmem_req = 0;
    rst_n = 1;
    settle();
    tests++;
    if (bus_req !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle bus_req=%b want=0", bus_req);
    end
    tick();
    settle();
    tests++;
    if ({grant_d, bus_addr, imem_ready, imem_rdata}
        !== {1'b0, 32'hC0, 1'b1, 32'h77}) begin
      fails++;
      $display("FAIL rstmid_fetch gd=%b addr=%h rdy=%b rd=%h",
               grant_d, bus_addr, imem_ready, imem_rdata);
    end
    tick();
    imem_req = 0;
  endtask

  task automatic test_random();
    // owner: 0 = nobody, 1 = fetch, 2 = data
    int owner;
    int waited;
    bit drop_i, drop_d;
    logic [67:0] e_bus;
    logic [33:0] e_i, e_d;
    do_reset();
    owner = 0; waited = 0;
    drop_i = 0; drop_d = 0;
    for (int n = 0; n < 400; n++) begin
      if (n != 0) tick();
      if (drop_i) imem_req = 0;
      if (drop_d) dmem_req = 0;
      drop_i = 0; drop_d = 0;
      if (!imem_req && ($urandom_range(0, 1) == 1)) begin
        imem_req = 1;
        imem_vaddr = $urandom;
        imem_write = 1'($urandom);
        imem_size = 2'($urandom);
        imem_wdata = $urandom;
      end
      if (!dmem_req && ($urandom_range(0, 1) == 1)) begin
        dmem_req = 1;
        dmem_vaddr = $urandom;
        dmem_write = 1'($urandom);
        dmem_size = 2'($urandom);
        dmem_wdata = $urandom;
      end
      bus_ready = ($urandom_range(0, 2) != 0);
      bus_abort = ($urandom_range(0, 7) == 0);
      bus_rdata = $urandom;
      settle();
      e_bus = '0; e_i = '0; e_d = '0;
      if (owner == 1) begin
        e_bus = {imem_req, imem_vaddr, imem_write,
                 imem_size, imem_wdata};
        e_i = {bus_ready, bus_abort, bus_rdata};
      end else if (owner == 2) begin
        e_bus = {dmem_req, dmem_vaddr, dmem_write,
                 dmem_size, dmem_wdata};
        e_d = {bus_ready, bus_abort, bus_rdata};
      end
      tests++;
      if (grant_d !== (owner == 2)) begin
        fails++;
        $display("FAIL rnd_grant n=%0d gd=%b owner=%0d",
                 n, grant_d, owner);
      end
      tests++;
      if ({bus_req, bus_addr, bus_write, bus_size, bus_wdata}
          !== e_bus) begin
        fails++;
        $display("FAIL rnd_bus n=%0d got=%h want=%h", n,
                 {bus_req, bus_addr, bus_write, bus_size, bus_wdata},
                 e_bus);
      end
      tests++;
      if ({imem_ready, imem_abort, imem_rdata} !== e_i) begin
        fails++;
        $display("FAIL rnd_iresp n=%0d got=%h want=%h", n,
                 {imem_ready, imem_abort, imem_rdata}, e_i);
      end
      tests++;
      if ({dmem_ready, dmem_abort, dmem_rdata} !== e_d) begin
        fails++;
        $display("FAIL rnd_dresp n=%0d got=%h want=%h", n,
                 {dmem_ready, dmem_abort, dmem_rdata}, e_d);
      end
      if (owner == 0) begin
        if (dmem_req && !(imem_req && waited >= LIMIT)) begin
          owner = 2;
          if (imem_req && waited < LIMIT) waited++;
        end else if (imem_req) begin
          owner = 1;
          waited = 0;
        end
      end else if (bus_ready || bus_abort) begin
        if (owner == 1) drop_i = 1;
        else drop_d = 1;
        owner = 0;
      end
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_lock();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
